pixel_lfsr_readout_array: RTL and testbench

//  Digital back-end for a row of NUM_PIX ramp-ADC pixels. Each channel runs an XNOR-feedback

---
 rtl/pixel_pkg.sv | 40 ++++
 rtl/pixel_lfsr_channel.sv | 93 +++++++++
 rtl/pixel_lfsr_readout_array.sv | 134 +++++++++++++
 tb/tb_pixel_lfsr_readout_array.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// -----------------------------------------------------------------------------
// pixel_pkg
// Shared types and constants for the pixel LFSR readout array.
//   state_t    : top-level sequencer states (IDLE, COUNT, READ)
//   ch_mode_t  : per-channel operating mode driven by the sequencer
//   TAPS_Wn    : default XNOR feedback tap masks for common counter widths
//   frame_len  : serial frame length per channel (code plus optional flag)
// Optional feature macro: PIX_OVF_FLAG_EN (adds one overflow flag bit per frame).
// -----------------------------------------------------------------------------
package pixel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        READ  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CH_HOLD  = 2'd0,
        CH_CLEAR = 2'd1,
        CH_COUNT = 2'd2,
        CH_SHIFT = 2'd3
    } ch_mode_t;

    // Maximal-length XNOR tap masks, bit i = counter bit i.
    localparam logic [7:0]  TAPS_W8  = 8'b1011_1000;
    localparam logic [9:0]  TAPS_W10 = 10'b10_0100_0000;
    localparam logic [11:0] TAPS_W12 = 12'b1000_0010_1001;

`ifdef PIX_OVF_FLAG_EN
    localparam int FLAG_BITS = 1;
`else
    localparam int FLAG_BITS = 0;
`endif

    function automatic int frame_len(input int width);
        return width + FLAG_BITS;
    endfunction

endpackage

// File: rtl/pixel_lfsr_channel.sv
// -----------------------------------------------------------------------------
// pixel_lfsr_channel
// One pixel channel: XNOR-feedback LFSR counter, sticky comparator latch and,
// with PIX_OVF_FLAG_EN defined, a "never fired" flag that precedes the code.
// Ports:
//   Clk, Rst    : clock, asynchronous active-high reset
//   mode        : CH_CLEAR / CH_COUNT / CH_HOLD / CH_SHIFT
//   comp        : comparator input, only looked at in CH_COUNT
//   count_last  : (flag build only) high on the final COUNT cycle
//   ser_in      : serial input, enters the code LSB while shifting
//   ser_out     : frame MSB (flag if present, else code MSB)
// -----------------------------------------------------------------------------
module pixel_lfsr_channel
    import pixel_pkg::*;
#(
    parameter int              WIDTH = 10,
    parameter logic [WIDTH-1:0] TAPS = TAPS_W10
) (
    input  logic     Clk,
    input  logic     Rst,
    input  ch_mode_t mode,
    input  logic     comp,
`ifdef PIX_OVF_FLAG_EN
    input  logic     count_last,
`endif
    input  logic     ser_in,
    output logic     ser_out
);

    logic [WIDTH-1:0] q;
    logic             latch;
    logic             fb;

    assign fb = ~^(q & TAPS);

`ifdef PIX_OVF_FLAG_EN
    logic flag;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            q     <= '0;
            latch <= 1'b0;
            flag  <= 1'b0;
        end else begin
            case (mode)
                CH_CLEAR: begin
                    q     <= '0;
                    latch <= 1'b0;
                    flag  <= 1'b0;
                end
                CH_COUNT: begin
                    // A rise on the last cycle still counts as a valid conversion.
                    if (comp)
                        latch <= 1'b1;
                    else if (!latch)
                        q <= {q[WIDTH-2:0], fb};
                    if (count_last)
                        flag <= ~(latch | comp);
                end
                CH_SHIFT: {flag, q} <= {q, ser_in};
                default: ;
            endcase
        end
    end

    assign ser_out = flag;
`else
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            q     <= '0;
            latch <= 1'b0;
        end else begin
            case (mode)
                CH_CLEAR: begin
                    q     <= '0;
                    latch <= 1'b0;
                end
                CH_COUNT: begin
                    if (comp)
                        latch <= 1'b1;
                    else if (!latch)
                        q <= {q[WIDTH-2:0], fb};
                end
                CH_SHIFT: q <= {q[WIDTH-2:0], ser_in};
                default: ;
            endcase
        end
    end

    assign ser_out = q[WIDTH-1];
`endif

endmodule

// File: rtl/pixel_lfsr_readout_array.sv
// -----------------------------------------------------------------------------
// pixel_lfsr_readout_array
// Back-end for a row of NUM_PIX ramp-ADC pixels. A start request clears all
// channels, runs RAMP_LEN counting cycles, then shifts every channel's frame
// out MSB-first on one daisy chain (channel NUM_PIX-1 first, channel 0 last).
// Optional feature macro: PIX_OVF_FLAG_EN (per-channel never-fired flag bit).
// Ports:
//   Clk, Rst : clock, asynchronous active-high reset
//   start    : one-cycle conversion request, honoured only in IDLE
//   comp     : comparator outputs, one per channel
//   ser_in   : chain input into channel 0
//   ser_out  : chain output, valid while ser_vld is high
//   ser_vld  : high for every READ cycle
//   busy     : high in COUNT and READ
//   done     : one-cycle pulse on the last READ cycle
// -----------------------------------------------------------------------------
module pixel_lfsr_readout_array
    import pixel_pkg::*;
#(
    parameter int               NUM_PIX  = 4,
    parameter int               WIDTH    = 10,
    parameter logic [WIDTH-1:0] TAPS     = TAPS_W10,
    parameter int               RAMP_LEN = 1023
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               start,
    input  logic [NUM_PIX-1:0] comp,
    input  logic               ser_in,
    output logic               ser_out,
    output logic               ser_vld,
    output logic               busy,
    output logic               done
);

    localparam int FRAME     = frame_len(WIDTH);
    localparam int SHIFT_LEN = NUM_PIX * FRAME;
    localparam int CNT_MAX   = (RAMP_LEN > SHIFT_LEN) ? RAMP_LEN : SHIFT_LEN;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RAMP_LAST   = CNT_W'(RAMP_LEN - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(SHIFT_LEN - 1);
    localparam logic [CNT_W-1:0] SHIFT_PENUL = CNT_W'(SHIFT_LEN - 2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    ch_mode_t         mode;
    logic             count_last;
    logic [NUM_PIX:0] chain;

    assign count_last = (state == COUNT) && (cnt == RAMP_LAST);

    always_comb begin
        mode = CH_HOLD;
        case (state)
            IDLE:    if (start) mode = CH_CLEAR;
            COUNT:   mode = CH_COUNT;
            READ:    mode = CH_SHIFT;
            default: mode = CH_HOLD;
        endcase
    end

    // Sequencer; busy/ser_vld/done are registered alongside the state.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            ser_vld <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COUNT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (count_last) begin
                        state   <= READ;
                        cnt     <= '0;
                        ser_vld <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READ: begin
                    // Raise done one cycle early so it coincides with the last bit.
                    done <= (cnt == SHIFT_PENUL);
                    if (cnt == SHIFT_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        busy    <= 1'b0;
                        ser_vld <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    busy    <= 1'b0;
                    ser_vld <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign chain[0] = ser_in;

    for (genvar i = 0; i < NUM_PIX; i++) begin : g_ch
        pixel_lfsr_channel #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_ch (
            .Clk        (Clk),
            .Rst        (Rst),
            .mode       (mode),
            .comp       (comp[i]),
`ifdef PIX_OVF_FLAG_EN
            .count_last (count_last),
`endif
            .ser_in     (chain[i]),
            .ser_out    (chain[i+1])
        );
    end

    // Gate so the line idles low outside READ.
    assign ser_out = ser_vld & chain[NUM_PIX];

endmodule

// File: tb/tb_pixel_lfsr_readout_array.sv
module tb_pixel_lfsr_readout_array;
    import pixel_pkg::*;

    localparam int NP    = 4;
    localparam int W     = 10;
    localparam int RL    = 1023;
    localparam int FRAME = frame_len(W);
    localparam int SL    = NP * FRAME;
    localparam logic [W-1:0] TB_TAPS = 10'h240;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          start;
    logic [NP-1:0] comp;
    logic          ser_in;
    logic          ser_out;
    logic          ser_vld;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    bit exp_q[$];
    int fire_cyc[NP];
    int drop_cyc[NP];
    int poke[3];
    int rst_at;

    pixel_lfsr_readout_array #(
        .NUM_PIX  (NP),
        .WIDTH    (W),
        .TAPS     (TB_TAPS),
        .RAMP_LEN (RL)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .start   (start),
        .comp    (comp),
        .ser_in  (ser_in),
        .ser_out (ser_out),
        .ser_vld (ser_vld),
        .busy    (busy),
        .done    (done)
    );

    always #5 Clk = ~Clk;

    function automatic logic [W-1:0] lfsr_adv(input int steps);
        logic [W-1:0] q;
        q = '0;
        for (int s = 0; s < steps; s++)
            q = {q[W-2:0], ~^(q & TB_TAPS)};
        return q;
    endfunction

    function automatic bit fired(input int ch);
        return (fire_cyc[ch] >= 0) && (fire_cyc[ch] < RL);
    endfunction

    // One full conversion with scoreboarded readout and per-cycle control checks.
    task automatic run_conv(input string tag);
        logic [W-1:0] code;
        bit           e;
        int           vld_cnt;
        int           done_cnt;
        vld_cnt  = 0;
        done_cnt = 0;
        for (int ch = NP - 1; ch >= 0; ch--) begin
`ifdef PIX_OVF_FLAG_EN
            exp_q.push_back(!fired(ch));
`endif
            code = lfsr_adv(fired(ch) ? fire_cyc[ch] : RL);
            for (int b = W - 1; b >= 0; b--)
                exp_q.push_back(code[b]);
        end
        @(negedge Clk);
        start = 1'b1;
        comp  = '0;
        @(negedge Clk);
        start = 1'b0;
        for (int n = 0; n <= RL + SL; n++) begin
            if (n == rst_at) begin
                Rst = 1'b1;
                #1;
                n_checks++;
                if ({busy, ser_vld, done, ser_out} !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL %s async_reset busy/vld/done/out got %b required 0000",
                             tag, {busy, ser_vld, done, ser_out});
                end
                exp_q.delete();
                @(negedge Clk);
                Rst = 1'b0;
                return;
            end
            start  = (n == poke[0]) || (n == poke[1]) || (n == poke[2]);
            ser_in = 1'($urandom);
            for (int i = 0; i < NP; i++)
                comp[i] = (fire_cyc[i] >= 0) && (n >= fire_cyc[i]) &&
                          ((drop_cyc[i] < 0) || (n < drop_cyc[i]));
            n_checks++;
            if (busy !== (n < RL + SL)) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d got %b required %b", tag, n, busy, (n < RL + SL));
            end
            n_checks++;
            if (ser_vld !== ((n >= RL) && (n < RL + SL))) begin
                n_fail++;
                $display("FAIL %s ser_vld cycle %0d got %b required %b", tag, n, ser_vld,
                         ((n >= RL) && (n < RL + SL)));
            end
            n_checks++;
            if (done !== (n == RL + SL - 1)) begin
                n_fail++;
                $display("FAIL %s done cycle %0d got %b required %b", tag, n, done, (n == RL + SL - 1));
            end
            if (done === 1'b1) done_cnt++;
            if (ser_vld === 1'b1) begin
                vld_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s ser_out cycle %0d got %b with no bit expected", tag, n, ser_out);
                end else begin
                    e = exp_q.pop_front();
                    if (ser_out !== e) begin
                        n_fail++;
                        $display("FAIL %s ser_out cycle %0d (bit %0d) got %b required %b",
                                 tag, n, vld_cnt - 1, ser_out, e);
                    end
                end
            end
            @(negedge Clk);
        end
        start = 1'b0;
        comp  = '0;
        n_checks++;
        if (vld_cnt != SL) begin
            n_fail++;
            $display("FAIL %s ser_vld_count got %0d required %0d", tag, vld_cnt, SL);
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL %s done_count got %0d required 1", tag, done_cnt);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s leftover_bits got %0d required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic set_defaults();
        drop_cyc = '{-1, -1, -1, -1};
        poke     = '{-1, -1, -1};
        rst_at   = -1;
    endtask

    task automatic test_reset();
        Rst    = 1'b1;
        start  = 1'b0;
        comp   = '0;
        ser_in = 1'b0;
        repeat (3) @(negedge Clk);
        n_checks++;
        if ({busy, ser_vld, done, ser_out} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset busy/vld/done/out got %b required 0000",
                     {busy, ser_vld, done, ser_out});
        end
        Rst = 1'b0;
        @(negedge Clk);
        n_checks++;
        if ({busy, ser_vld, done, ser_out} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release busy/vld/done/out got %b required 0000",
                     {busy, ser_vld, done, ser_out});
        end
    endtask

    task automatic test_convert_basic();
        set_defaults();
        fire_cyc = '{0, 3, 100, -1};
        run_conv("convert_basic");
    endtask

    task automatic test_readout_order();
        set_defaults();
        fire_cyc = '{2, 7, 13, 20};
        run_conv("readout_order");
    endtask

    task automatic test_never_fired();
        set_defaults();
        fire_cyc = '{50, 60, -1, 900};
        run_conv("never_fired");
    endtask

    task automatic test_pulse_freeze();
        set_defaults();
        fire_cyc = '{1, 2, 3, 5};
        drop_cyc = '{-1, 4, -1, 6};
        run_conv("pulse_freeze");
    endtask

    task automatic test_start_while_busy();
        set_defaults();
        fire_cyc = '{4, 8, 16, 32};
        poke     = '{100, RL + 5, RL + SL - 1};
        run_conv("start_while_busy");
    endtask

    task automatic test_reset_mid_count();
        set_defaults();
        fire_cyc = '{10, 20, 700, -1};
        rst_at   = 500;
        run_conv("reset_mid_count");
        set_defaults();
        fire_cyc = '{500, 1000, 1022, 0};
        run_conv("after_reset");
    endtask

    initial begin
        test_reset();
        test_convert_basic();
        test_readout_order();
        test_never_fired();
        test_pulse_freeze();
        test_start_while_busy();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
